// File: rtl/core_arb_pkg.sv
// Shared types and constants for the core-protocol request arbiter.
package core_arb_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } arb_state_t;

  localparam int unsigned CORE_DATA_WIDTH = 32;
  localparam int unsigned CORE_BE_WIDTH   = 4;

endpackage

// File: rtl/core_arb_id_fifo.sv
// Small FIFO of requester IDs for granted-but-unanswered transactions.
module core_arb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             push_en, pop_en;

  // Explicit wrap so non-power-of-2 or single-entry depths stay in range.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_en) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_en && !pop_en) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop_en && !push_en) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/core_req_arbiter.sv
// Round-robin arbiter sharing one core-protocol slave port among NB_REQ requesters,
// steering each response back to its issuer through an ID FIFO.
module core_req_arbiter
  import core_arb_pkg::*;
#(
  parameter int unsigned NB_REQ          = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NB_REQ-1:0]                   m_req_i,
  output logic [NB_REQ-1:0]                   m_gnt_o,
  output logic [NB_REQ-1:0]                   m_rvalid_o,
  input  logic [NB_REQ*ADDR_WIDTH-1:0]        m_addr_i,
  input  logic [NB_REQ-1:0]                   m_we_i,
  input  logic [NB_REQ*CORE_BE_WIDTH-1:0]     m_be_i,
  input  logic [NB_REQ*CORE_DATA_WIDTH-1:0]   m_wdata_i,
  output logic [CORE_DATA_WIDTH-1:0]          m_rdata_o,
  output logic                                s_req_o,
  input  logic                                s_gnt_i,
  input  logic                                s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]               s_addr_o,
  output logic                                s_we_o,
  output logic [CORE_BE_WIDTH-1:0]            s_be_o,
  output logic [CORE_DATA_WIDTH-1:0]          s_wdata_o,
  input  logic [CORE_DATA_WIDTH-1:0]          s_rdata_i,
  output logic                                err_o
);

  localparam int unsigned IdW = $clog2(NB_REQ);

  arb_state_t     state_q;
  logic [IdW-1:0] rr_q, lock_q;
  logic           err_q;
  logic [IdW-1:0] search_sel, sel, sel_next;
  logic           any_req, grant;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [IdW-1:0] fifo_head;
  int unsigned    idx;

  // First requesting index at or above rr_q, modulo NB_REQ.
  always_comb begin
    search_sel = rr_q;
    idx        = 0;
    for (int unsigned i = NB_REQ; i > 0; i--) begin
      idx = (int'(rr_q) + i - 1) % NB_REQ;
      if (m_req_i[idx]) search_sel = IdW'(idx);
    end
  end

  assign sel      = (state_q == WAIT_GNT) ? lock_q : search_sel;
  assign sel_next = IdW'((int'(sel) + 1) % NB_REQ);
  assign any_req  = (state_q == WAIT_GNT) ? m_req_i[lock_q] : |m_req_i;

  assign s_req_o   = any_req & ~fifo_full & ~rst_i;
  assign grant     = s_req_o & s_gnt_i;
  assign fifo_pop  = s_rvalid_i & ~fifo_empty & ~rst_i;
  assign m_rdata_o = s_rdata_i;
  assign err_o     = err_q;

  always_comb begin
    s_addr_o   = m_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
    s_we_o     = m_we_i[sel];
    s_be_o     = m_be_i[int'(sel)*CORE_BE_WIDTH +: CORE_BE_WIDTH];
    s_wdata_o  = m_wdata_i[int'(sel)*CORE_DATA_WIDTH +: CORE_DATA_WIDTH];
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (grant) m_gnt_o[sel] = 1'b1;
    if (fifo_pop) m_rvalid_o[fifo_head] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      lock_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (s_rvalid_i && fifo_empty) err_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            rr_q <= sel_next;
          end else if (s_req_o) begin
            lock_q  <= search_sel;
            state_q <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (grant) begin
            rr_q    <= sel_next;
            state_q <= IDLE;
          end else if (!fifo_full && !m_req_i[lock_q]) begin
            // Requester withdrew without a grant; drop the lock.
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  core_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IdW)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (grant),
    .push_data_i (sel),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

endmodule
